// File: rtl/mem_access_stage.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_stage
// Description : Memory-access stage of the basic pipeline. Accepts one
//               instruction per cycle. It performs loads and stores on a
//               req/ack data bus and stalls upstream while an access is
//               outstanding. It registers the write-back bundle.
//               It also does lane steering, load extension, byte enables
//               and misalignment detection.
// Ports       : clk, rst_n             - clock, async active-low reset
//               ValidIn .. RegDstIn    - EX/MA instruction bundle
//               StallOut               - upstream must hold its inputs
//               MemReq/We/Addr/WData/Be, MemAck/MemRData - data bus
//               ValidOut .. RegDstOut  - registered write-back bundle
//               AlignErrOut            - registered misalignment pulse
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ValidIn,
    input  logic [31:0] ResultIn,
    input  logic [31:0] Imm32In,
    input  logic [31:0] AddrIn,
    input  logic [31:0] StoreDataIn,
    input  logic        MemReadIn,
    input  logic        MemWriteIn,
    input  logic [1:0]  MemSizeIn,
    input  logic        MemSignedIn,
    input  logic [1:0]  SelectorIn,
    input  logic        RegWriteIn,
    input  logic [4:0]  RegDstIn,
    output logic        StallOut,
    output logic        MemReq,
    output logic        MemWe,
    output logic [31:0] MemAddr,
    output logic [31:0] MemWData,
    output logic [3:0]  MemBe,
    input  logic        MemAck,
    input  logic [31:0] MemRData,
    output logic        ValidOut,
    output logic [31:0] ResultOut,
    output logic [31:0] Imm32Out,
    output logic [31:0] DataOut,
    output logic [31:0] AddrOut,
    output logic [1:0]  SelectorOut,
    output logic        RegWriteOut,
    output logic [4:0]  RegDstOut,
    output logic        AlignErrOut
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // Holding registers for the instruction being serviced on the bus
    logic [31:0] r_h_result;
    logic [31:0] r_h_imm;
    logic [31:0] r_h_addr;
    logic [31:0] r_h_sdata;
    logic        r_h_load;
    logic        r_h_store;
    logic [1:0]  r_h_size;
    logic        r_h_signed;
    logic [1:0]  r_h_sel;
    logic        r_h_regwrite;
    logic [4:0]  r_h_regdst;

    logic        w_is_mem;
    logic        w_misalign;
    logic        w_accept;
    logic [1:0]  w_lane;
    logic [7:0]  w_ld_byte;
    logic [15:0] w_ld_half;
    logic [31:0] w_ld_data;
    logic [31:0] w_st_data;
    logic [3:0]  w_st_be;

    // ------------------------------------------------------------------------
    // Decode of the incoming instruction
    // ------------------------------------------------------------------------
    assign w_is_mem   = MemReadIn | MemWriteIn;
    // Size 3 decodes as word, so bit 1 alone identifies a word access.
    assign w_misalign = ((MemSizeIn == 2'd1) & ResultIn[0]) |
                        (MemSizeIn[1] & (|ResultIn[1:0]));
    assign w_accept   = (r_state == S_IDLE) & ValidIn & w_is_mem & ~w_misalign;

    // ------------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_nxt = S_WAIT;
            S_WAIT:  if (MemAck)   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // Holding registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_h_result   <= 32'd0;
            r_h_imm      <= 32'd0;
            r_h_addr     <= 32'd0;
            r_h_sdata    <= 32'd0;
            r_h_load     <= 1'b0;
            r_h_store    <= 1'b0;
            r_h_size     <= 2'd0;
            r_h_signed   <= 1'b0;
            r_h_sel      <= 2'd0;
            r_h_regwrite <= 1'b0;
            r_h_regdst   <= 5'd0;
        end else if (w_accept) begin
            r_h_result   <= ResultIn;
            r_h_imm      <= Imm32In;
            r_h_addr     <= AddrIn;
            r_h_sdata    <= StoreDataIn;
            r_h_load     <= MemReadIn;
            // A load+store combination is serviced as a plain load.
            r_h_store    <= MemWriteIn & ~MemReadIn;
            r_h_size     <= MemSizeIn;
            r_h_signed   <= MemSignedIn;
            r_h_sel      <= SelectorIn;
            r_h_regwrite <= RegWriteIn;
            r_h_regdst   <= RegDstIn;
        end
    end

    // ------------------------------------------------------------------------
    // Lane steering (stores) and extraction (loads)
    // ------------------------------------------------------------------------
    assign w_lane = r_h_result[1:0];

    always_comb begin
        w_ld_byte = MemRData[7:0];
        case (w_lane)
            2'd0: w_ld_byte = MemRData[7:0];
            2'd1: w_ld_byte = MemRData[15:8];
            2'd2: w_ld_byte = MemRData[23:16];
            2'd3: w_ld_byte = MemRData[31:24];
            default: w_ld_byte = MemRData[7:0];
        endcase
    end

    assign w_ld_half = w_lane[1] ? MemRData[31:16] : MemRData[15:0];

    always_comb begin
        w_ld_data = MemRData;
        w_st_data = r_h_sdata;
        w_st_be   = 4'b1111;
        case (r_h_size)
            2'd0: begin
                w_ld_data = {{24{r_h_signed & w_ld_byte[7]}}, w_ld_byte};
                w_st_data = {4{r_h_sdata[7:0]}};
                w_st_be   = 4'b0001 << w_lane;
            end
            2'd1: begin
                w_ld_data = {{16{r_h_signed & w_ld_half[15]}}, w_ld_half};
                w_st_data = {2{r_h_sdata[15:0]}};
                w_st_be   = w_lane[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                w_ld_data = MemRData;
                w_st_data = r_h_sdata;
                w_st_be   = 4'b1111;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Bus outputs: driven purely from state and holding registers so they
    // stay stable for the whole WAIT period and drop at once on reset.
    // ------------------------------------------------------------------------
    assign StallOut = (r_state == S_WAIT);
    assign MemReq   = (r_state == S_WAIT);
    assign MemWe    = MemReq & r_h_store;
    assign MemAddr  = {r_h_result[31:2], 2'b00};
    assign MemWData = MemWe ? w_st_data : 32'd0;
    assign MemBe    = MemWe ? w_st_be : 4'b0000;

    // ------------------------------------------------------------------------
    // Write-back bundle. Data fields only move on a valid result; the valid,
    // register-write and alignment flags are per-instruction pulses.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ValidOut    <= 1'b0;
            ResultOut   <= 32'd0;
            Imm32Out    <= 32'd0;
            DataOut     <= 32'd0;
            AddrOut     <= 32'd0;
            SelectorOut <= 2'd0;
            RegWriteOut <= 1'b0;
            RegDstOut   <= 5'd0;
            AlignErrOut <= 1'b0;
        end else begin
            ValidOut    <= 1'b0;
            RegWriteOut <= 1'b0;
            AlignErrOut <= 1'b0;
            if (r_state == S_WAIT) begin
                if (MemAck) begin
                    ValidOut    <= 1'b1;
                    RegWriteOut <= r_h_regwrite;
                    ResultOut   <= r_h_result;
                    Imm32Out    <= r_h_imm;
                    AddrOut     <= r_h_addr;
                    SelectorOut <= r_h_sel;
                    RegDstOut   <= r_h_regdst;
                    DataOut     <= r_h_load ? w_ld_data : 32'd0;
                end
            end else if (ValidIn && (!w_is_mem || w_misalign)) begin
                // Non-memory op, or a misaligned access that is reported
                // instead of being issued; the latter never writes a register.
                ValidOut    <= 1'b1;
                RegWriteOut <= RegWriteIn & ~w_is_mem;
                AlignErrOut <= w_is_mem;
                ResultOut   <= ResultIn;
                Imm32Out    <= Imm32In;
                AddrOut     <= AddrIn;
                SelectorOut <= SelectorIn;
                RegDstOut   <= RegDstIn;
                DataOut     <= 32'd0;
            end
        end
    end

endmodule
`default_nettype wire
